skullfet_exerciser: RTL and testbench

Stimulus and checker stage for the SkullFET inverter cell. Drives the inverter's A input with a programmable square wave and samples its Y output through a synchroniser. Counts Y edges and A/Y logic mismatches. Instantiated alongside the inverter inside the SkullFET project wrapper: control comes from LA inputs, results go to LA outputs, and raw A/Y are also routed to IO pads for scope probing.

---
 rtl/skullfet_exerciser.sv | 123 ++++++++++++
 tb/tb_skullfet_exerciser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/skullfet_exerciser.sv
// Square-wave stimulus and synchronised checker for the SkullFET inverter cell.
// Drives A with a programmable half-period and counts Y edges and A/Y agreement errors.
module skullfet_exerciser #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 24
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] half_period,
    input  logic [CNT_W-1:0] num_halves,
    output logic             dut_a,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] error_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             a_q, a_d;
    logic             y_meta_q, y_meta_d;
    logic             y_s_q, y_s_d;
    logic             y_s_dly_q, y_s_dly_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             free_q, free_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [DIV_W-1:0] h_eff;

    assign h_eff = (half_period < DIV_W'(3)) ? DIV_W'(3) : half_period;

    // start and stop are plain levels sampled every cycle; there is no handshake.
    // start is acted on only in IDLE/DONE, stop only in RUN, and stop beats a
    // divider expiry in the same cycle.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        y_meta_d  = dut_y;
        y_s_d     = y_meta_q;
        y_s_dly_d = y_s_q;
        div_d     = div_q;
        h_d       = h_q;
        rem_d     = rem_q;
        free_d    = free_q;
        edge_d    = edge_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                a_d = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                    a_d     = 1'b1;
                    edge_d  = '0;
                    err_d   = '0;
                    h_d     = h_eff;
                    div_d   = h_eff;
                    rem_d   = num_halves;
                    free_d  = (num_halves == '0);
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DONE;
                end else begin
                    div_d = div_q - 1'b1;
                    if ((y_s_q != y_s_dly_q) && !(&edge_q)) edge_d = edge_q + 1'b1;
                    if (div_q == DIV_W'(1)) begin
                        if ((y_s_q == a_q) && !(&err_q)) err_d = err_q + 1'b1;
                        div_d = h_q;
                        if (!free_q) rem_d = rem_q - 1'b1;
                        // A holds its level on the edge that ends the run.
                        if (free_q || (rem_q != CNT_W'(1))) a_d = ~a_q;
                        else state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            a_q       <= 1'b0;
            y_meta_q  <= 1'b1;
            y_s_q     <= 1'b1;
            y_s_dly_q <= 1'b1;
            div_q     <= '0;
            h_q       <= '0;
            rem_q     <= '0;
            free_q    <= 1'b0;
            edge_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            y_meta_q  <= y_meta_d;
            y_s_q     <= y_s_d;
            y_s_dly_q <= y_s_dly_d;
            div_q     <= div_d;
            h_q       <= h_d;
            rem_q     <= rem_d;
            free_q    <= free_d;
            edge_q    <= edge_d;
            err_q     <= err_d;
        end
    end

    assign dut_a       = a_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign edge_count  = edge_q;
    assign error_count = err_q;

endmodule

// File: tb/tb_skullfet_exerciser.sv
// Directed bench for skullfet_exerciser with an ideal/stuck inverter model on dut_y.
module tb_skullfet_exerciser;

    localparam int DIV_W = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] half_period;
    logic [CNT_W-1:0] num_halves;
    logic             dut_a;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edge_count;
    logic [CNT_W-1:0] error_count;
    logic             ideal;
    logic             stuck_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Inverter model: ideal inverter, or Y stuck at a constant.
    assign dut_y = ideal ? ~dut_a : stuck_val;

    skullfet_exerciser #(.DIV_W(DIV_W), .CNT_W(CNT_W)) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .num_halves  (num_halves),
        .dut_a       (dut_a),
        .dut_y       (dut_y),
        .busy        (busy),
        .done        (done),
        .edge_count  (edge_count),
        .error_count (error_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts a run and follows it cycle by cycle; samples on negedges.
    task automatic run(input string name, input int hp, input int n, input int h_eff,
                       input int exp_edges, input int exp_err, input int restart_at);
        int total;
        total = n * h_eff;
        half_period = DIV_W'(hp);
        num_halves  = CNT_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_clr_edge"}, edge_count, 0);
        check({name, "_clr_err"}, error_count, 0);
        for (int k = 1; k <= total; k++) begin
            check($sformatf("%s_busy_k%0d", name, k), busy, 1);
            check($sformatf("%s_a_k%0d", name, k), dut_a, (((k - 1) / h_eff) % 2 == 0) ? 1 : 0);
            start = (k == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done"}, done, 1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_edges"}, edge_count, exp_edges);
        check({name, "_errors"}, error_count, exp_err);
        @(negedge clk);
        check({name, "_a_done"}, dut_a, 0);
        tick(4);
        check({name, "_edges_hold"}, edge_count, exp_edges);
        check({name, "_errors_hold"}, error_count, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        half_period = '0;
        num_halves = '0;
        ideal = 1'b0;
        stuck_val = 1'b1;
        tick(3);
        rst = 1'b0;

        // Idle after reset with Y high; stop in IDLE is ignored.
        for (int i = 0; i < 5; i++) begin
            stop = (i == 2);
            @(negedge clk);
            check("idle_a", dut_a, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_edges", edge_count, 0);
            check("idle_errors", error_count, 0);
        end
        stop = 1'b0;

        // Ideal inverter, H=5, 4 halves; a start pulse mid-run is ignored.
        ideal = 1'b1;
        run("ideal5x4", 5, 4, 5, 4, 0, 8);

        // Y stuck high: odd halves (A=1) mismatch.
        ideal = 1'b0;
        stuck_val = 1'b1;
        run("stuck4x6", 4, 6, 4, 0, 3, 0);

        // half_period below minimum clamps to 3.
        ideal = 1'b1;
        run("clamp0x2", 0, 2, 3, 2, 0, 0);

        // Free-run, stop after 10 RUN cycles.
        half_period = DIV_W'(3);
        num_halves = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(9);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_done", done, 1);
        check("stop_busy", busy, 0);
        check("stop_edges", edge_count, 3);
        check("stop_errors", error_count, 0);
        tick(6);
        check("stop_edges_frozen", edge_count, 3);
        check("stop_errors_frozen", error_count, 0);
        check("stop_a_done", dut_a, 0);
        run("after_stop", 3, 2, 3, 2, 0, 0);

        // Stop coinciding with the first divider expiry: no compare is made.
        ideal = 1'b0;
        stuck_val = 1'b1;
        half_period = DIV_W'(3);
        num_halves = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_prio_done", done, 1);
        check("stop_prio_errors", error_count, 0);
        tick(4);

        // Reset mid-run clears everything; a following run is normal.
        ideal = 1'b1;
        half_period = DIV_W'(5);
        num_halves = CNT_W'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(4);
        check("pre_rst_edges", edge_count, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_a", dut_a, 0);
        check("rst_edges", edge_count, 0);
        check("rst_errors", error_count, 0);
        tick(4);
        run("after_rst", 4, 2, 4, 2, 0, 0);

        // Edge counter saturates rather than wrapping (300 edges, 8-bit counter).
        half_period = DIV_W'(3);
        num_halves = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(900);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("sat_edges", edge_count, 255);
        check("sat_edges_err", error_count, 0);
        tick(4);

        // Error counter saturates (about 260 mismatching halves).
        ideal = 1'b0;
        stuck_val = 1'b1;
        tick(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(1560);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("sat_errors", error_count, 255);
        check("sat_errors_edges", edge_count, 0);
        check("sat_errors_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
